// File: rtl/chu_timer_pkg.sv
// Shared constants for the FPRO timer slot: register offsets, CTRL bit positions
// and the counter width.
package chu_timer_pkg;

  localparam int unsigned W_CNT = 48;

  localparam logic [4:0] CNT_LO = 5'd0;
  localparam logic [4:0] CNT_HI = 5'd1;
  localparam logic [4:0] CTRL   = 5'd2;
  localparam logic [4:0] CMP_LO = 5'd3;
  localparam logic [4:0] CMP_HI = 5'd4;
  localparam logic [4:0] STATUS = 5'd5;

  localparam int unsigned GO       = 0;
  localparam int unsigned CLR      = 1;
  localparam int unsigned PERIODIC = 2;
  localparam int unsigned IRQ_EN   = 3;

endpackage

// File: rtl/chu_timer_core.sv
// 48-bit free-running cycle counter with compare match, periodic auto-reload and a
// level interrupt, exposed as a single-cycle FPRO MMIO slot.
module chu_timer_core
  import chu_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam logic [W_CNT-1:0] CntOne = W_CNT'(1);

  logic [W_CNT-1:0] r_count;
  logic [W_CNT-1:0] r_cmp;
  logic [15:0]      r_shadow_hi;
  logic             r_go;
  logic             r_periodic;
  logic             r_irq_en;
  logic             r_match_flag;

  logic             w_wr;
  logic             w_rd;
  logic             w_wr_ctrl;
  logic             w_clear;
  logic             w_match;
  logic [W_CNT-1:0] w_count_d;

  assign w_wr      = cs && write;
  assign w_rd      = cs && read;
  assign w_wr_ctrl = w_wr && (addr == CTRL);
  assign w_clear   = w_wr_ctrl && wr_data[CLR];
  assign w_match   = r_go && (r_count == r_cmp);

  // Hold is an explicit self-assignment so the register is always driven by this path.
  always_comb begin
    w_count_d = r_count;
    if (w_clear) begin
      w_count_d = '0;
    end else if (r_go && r_periodic && w_match) begin
      w_count_d = '0;
    end else if (r_go) begin
      w_count_d = r_count + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_cmp        <= '1;
      r_shadow_hi  <= '0;
      r_go         <= 1'b0;
      r_periodic   <= 1'b0;
      r_irq_en     <= 1'b0;
      r_match_flag <= 1'b0;
    end else begin
      r_count <= w_count_d;
      if (w_rd && (addr == CNT_LO)) begin
        r_shadow_hi <= r_count[47:32];
      end
      if (w_wr_ctrl) begin
        r_go       <= wr_data[GO];
        r_periodic <= wr_data[PERIODIC];
        r_irq_en   <= wr_data[IRQ_EN];
      end
      if (w_wr && (addr == CMP_LO)) begin
        r_cmp[31:0] <= wr_data;
      end
      if (w_wr && (addr == CMP_HI)) begin
        r_cmp[47:32] <= wr_data[15:0];
      end
      // A match in the same cycle as a W1C wins.
      if (w_match) begin
        r_match_flag <= 1'b1;
      end else if (w_wr && (addr == STATUS) && wr_data[0]) begin
        r_match_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (addr)
      CNT_LO:  rd_data = r_count[31:0];
      CNT_HI:  rd_data = {16'h0, r_shadow_hi};
      CTRL:    rd_data = {28'h0, r_irq_en, r_periodic, 1'b0, r_go};
      CMP_LO:  rd_data = r_cmp[31:0];
      CMP_HI:  rd_data = {16'h0, r_cmp[47:32]};
      STATUS:  rd_data = {31'h0, r_match_flag};
      default: rd_data = 32'h0;
    endcase
  end

  assign irq = r_match_flag && r_irq_en;

endmodule

// File: tb/tb_chu_timer_core.sv
// Self-checking bench for chu_timer_core: register tables plus hand-written
// sequences for counting, wrap, shadow latch, periodic match and W1C races.
module tb_chu_timer_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  always #5 clk = ~clk;

  chu_timer_core dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  typedef struct {
    logic        do_wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        rst_tab[8];
  vec_t        rb_tab[6];
  logic [31:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got);
    logic [31:0] exp;
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  // Reads sample the combinational rd_data mid-cycle; the following edge latches shadow_hi.
  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    sb_q.push_back(exp);
    #1;
    chk(name, rd_data);
    @(posedge clk);
    #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic irq_chk(input string name, input logic exp);
    sb_q.push_back({31'h0, exp});
    chk(name, {31'h0, irq});
  endtask

  task automatic run_rst_table(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("%s_rd%0d", tag, i), rst_tab[i].addr, rst_tab[i].exp);
    end
    irq_chk({tag, "_irq"}, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rst_tab[i] = '{1'b0, 5'(i), 32'h0, 32'h0};
    end
    rst_tab[3].exp = 32'hFFFF_FFFF;
    rst_tab[4].exp = 32'h0000_FFFF;

    rb_tab[0] = '{1'b1, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    rb_tab[1] = '{1'b1, 5'd4,  32'hABCD_1234, 32'h0000_1234};
    rb_tab[2] = '{1'b1, 5'd2,  32'h0000_000E, 32'h0000_000C};
    rb_tab[3] = '{1'b1, 5'd6,  32'hFFFF_FFFF, 32'h0000_0000};
    rb_tab[4] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
    rb_tab[5] = '{1'b1, 5'd5,  32'h0000_0001, 32'h0000_0000};

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_rst_table("rst");

    for (int i = 0; i < 6; i++) begin
      if (rb_tab[i].do_wr) wr(rb_tab[i].addr, rb_tab[i].wdata);
      rd($sformatf("rb%0d", i), rb_tab[i].addr, rb_tab[i].exp);
    end

    // Free run for 100 edges after go.
    wr(5'd2, 32'h1);
    repeat (100) @(posedge clk);
    rd("run_lo", 5'd0, 32'd100);
    rd("run_hi", 5'd1, 32'd0);
    wr(5'd2, 32'h2);
    rd("clr_lo", 5'd0, 32'd0);

    // 48-bit wrap: FFFF_FFFF_FFFE -> FFFF_FFFF_FFFF -> 0 -> 1, cmp far away.
    wr(5'd3, 32'd5);
    wr(5'd4, 32'd0);
    @(negedge clk);
    force dut.r_count = 48'hFFFF_FFFF_FFFE;
    @(posedge clk);
    #1 release dut.r_count;
    wr(5'd2, 32'h1);
    repeat (3) @(posedge clk);
    rd("wrap_lo", 5'd0, 32'd1);
    rd("wrap_hi", 5'd1, 32'd0);
    rd("wrap_flag", 5'd5, 32'd0);
    wr(5'd2, 32'h2);

    // Shadow latch across a low-word rollover.
    @(negedge clk);
    force dut.r_count = 48'h0000_FFFF_FFFE;
    @(posedge clk);
    #1 release dut.r_count;
    wr(5'd2, 32'h1);
    @(posedge clk);
    rd("shd_lo0", 5'd0, 32'hFFFF_FFFF);
    rd("shd_hi0", 5'd1, 32'h0);
    rd("shd_lo1", 5'd0, 32'h1);
    rd("shd_hi1", 5'd1, 32'h1);
    wr(5'd2, 32'h2);

    // Periodic match every cmp+1 = 10 cycles with irq enabled.
    wr(5'd3, 32'd9);
    wr(5'd4, 32'd0);
    wr(5'd5, 32'h1);
    wr(5'd2, 32'hD);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1 irq_chk($sformatf("per_a%0d", k), k == 10);
    end
    wr(5'd5, 32'h1);
    irq_chk("per_w1c", 1'b0);
    for (int k = 12; k <= 20; k++) begin
      @(posedge clk);
      #1 irq_chk($sformatf("per_b%0d", k), k == 20);
    end
    wr(5'd5, 32'h1);
    irq_chk("per_w1c2", 1'b0);
    repeat (8) @(posedge clk);
    wr(5'd5, 32'h1);
    irq_chk("race_irq", 1'b1);
    rd("race_flag", 5'd5, 32'h1);

    // Clear while running: zero after the write edge, then counting resumes.
    wr(5'd2, 32'h3);
    rd("clrgo_0", 5'd0, 32'd0);
    rd("clrgo_1", 5'd0, 32'd1);
    irq_chk("clrgo_irq", 1'b0);
    rd("clrgo_ctrl", 5'd2, 32'h1);

    // Reset overrides a concurrent write.
    @(negedge clk);
    reset = 1'b1; cs = 1'b1; write = 1'b1; addr = 5'd3; wr_data = 32'h1234;
    @(posedge clk);
    #1;
    reset = 1'b0; cs = 1'b0; write = 1'b0;
    run_rst_table("rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
